// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the shift-add multiplier and its neighbouring datapath blocks.
package seq_multiplier_pkg;

    localparam int unsigned DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_mult_step.sv
// One shift-add iteration: accumulate the shifted multiplicand when the multiplier LSB is set.
module seq_mult_step #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] acc_i,
    input  logic [W-1:0] mcand_i,
    input  logic         mplier_lsb_i,
    output logic [W-1:0] acc_o
);

    always_comb begin
        acc_o = acc_i;
        if (mplier_lsb_i) begin
            acc_o = acc_i + mcand_i;
        end
    end

endmodule

// File: rtl/seq_multiplier.sv
// Fixed-latency unsigned shift-add multiplier; done pulses once per product to load
// the downstream datapath register.
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             overflow
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q;
    logic [PW-1:0]    acc_q;
    logic [PW-1:0]    mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [CW-1:0]    count_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_hi_q;
    logic             overflow_q;
    logic [PW-1:0]    acc_d;

    seq_mult_step #(.W(PW)) u_step (
        .acc_i        (acc_q),
        .mcand_i      (mcand_q),
        .mplier_lsb_i (mplier_q[0]),
        .acc_o        (acc_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            count_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        mcand_q  <= PW'(a);
                        mplier_q <= b;
                        acc_q    <= '0;
                        count_q  <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    count_q  <= count_q + CW'(1);
                    // Final iteration: publish the product straight from the adder output.
                    if (count_q == LAST) begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        result_q    <= acc_d[WIDTH-1:0];
                        result_hi_q <= acc_d[PW-1:WIDTH];
                        overflow_q  <= |acc_d[PW-1:WIDTH];
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: vector table plus hand-written multi-cycle sequences.
module tb_seq_multiplier;

    localparam int unsigned WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             overflow;
    logic [WIDTH-1:0] dreg_q;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] lo;
        logic [WIDTH-1:0] hi;
        logic             ovf;
    } vec_t;

    vec_t vecs[10];

    seq_multiplier #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .result_hi (result_hi),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Downstream load-enabled datapath register.
    always @(posedge clk) begin
        if (rst)       dreg_q <= '0;
        else if (done) dreg_q <= result;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive a start request; returns at the falling edge after the accepting edge.
    task automatic start_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts falling edges until done is seen, bounded.
    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (done === 1'b1) break;
        end
    endtask

    task automatic run_checked(input vec_t v);
        bit window_ok;
        window_ok = 1'b1;
        start_op(v.a, v.b);
        for (int c = 1; c <= int'(WIDTH); c++) begin
            if (c > 1) @(negedge clk);
            if (!(busy === 1'b1 && done === 1'b0)) window_ok = 1'b0;
        end
        check("busy_window", 64'(window_ok), 64'd1);
        @(negedge clk);
        check("done_pulse", {62'd0, done, busy}, 64'b10);
        check("result", 64'(result), 64'(v.lo));
        check("result_hi", 64'(result_hi), 64'(v.hi));
        check("overflow", 64'(overflow), 64'(v.ovf));
        @(negedge clk);
        check("done_drop", 64'(done), 64'd0);
        check("reg_load", 64'(dreg_q), 64'(v.lo));
        repeat (3) @(negedge clk);
        check("result_hold", 64'(result), 64'(v.lo));
        check("reg_hold", 64'(dreg_q), 64'(v.lo));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int l2;
        bit seen;

        vecs[0] = '{16'h0003, 16'h0005, 16'h000F, 16'h0000, 1'b0};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b1};
        vecs[2] = '{16'h0100, 16'h0100, 16'h0000, 16'h0001, 1'b1};
        vecs[3] = '{16'h0000, 16'h1234, 16'h0000, 16'h0000, 1'b0};
        vecs[4] = '{16'h1234, 16'h0000, 16'h0000, 16'h0000, 1'b0};
        vecs[5] = '{16'h1234, 16'h5678, 16'h0060, 16'h0626, 1'b1};
        vecs[6] = '{16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0};
        vecs[7] = '{16'h8000, 16'h0002, 16'h0000, 16'h0001, 1'b1};
        vecs[8] = '{16'h00FF, 16'h0002, 16'h01FE, 16'h0000, 1'b0};
        vecs[9] = '{16'h0007, 16'h0009, 16'h003F, 16'h0000, 1'b0};

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_flags", {61'd0, busy, done, overflow}, 64'd0);
        check("reset_result", {32'd0, result_hi, result}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run_checked(vecs[i]);

        // Start and operand changes during RUN must not disturb the product in flight.
        start_op(16'd7, 16'd9);
        repeat (4) @(negedge clk);
        a     = 16'd2;
        b     = 16'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = 16'hAAAA;
        b     = 16'h5555;
        wait_done(lat);
        check("ignored_start_latency", 64'(lat), 64'(WIDTH + 1 - 6));
        check("ignored_start_result", 64'(result), 64'h003F);
        @(negedge clk);
        run_checked('{16'd2, 16'd2, 16'h0004, 16'h0000, 1'b0});

        // Held start: back-to-back products every WIDTH+2 cycles.
        @(negedge clk);
        a     = 16'd3;
        b     = 16'd5;
        start = 1'b1;
        wait_done(lat);
        wait_done(l2);
        start = 1'b0;
        check("throughput", 64'(l2), 64'(WIDTH + 2));
        check("throughput_result", 64'(result), 64'h000F);
        repeat (2) @(negedge clk);

        // Abort mid-RUN: outputs clear, no done pulse for the aborted operation.
        start_op(16'h1234, 16'h0002);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_flags", {61'd0, busy, done, overflow}, 64'd0);
        check("abort_result", {32'd0, result_hi, result}, 64'd0);
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        check("abort_no_done", 64'(seen), 64'd0);
        run_checked('{16'd4, 16'd4, 16'h0010, 16'h0000, 1'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
